// File: rtl/ds_pkg.sv
// Shared types and constants for the diamond-square tile scheduler.
// Holds the FSM state enum, seed stride and coordinate width.
package ds_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SEL,
    S_ACK,
    S_LAT,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;
  localparam int ACK_LAT_DEF = 3;
  localparam int CRD_W = 10;

  function automatic logic [31:0] tile_seed_of(
    input logic [31:0] s,
    input int i
  );
    return s ^ (32'(i) * SEED_STRIDE);
  endfunction

endpackage

// File: rtl/ds_tile_scheduler_if.sv
// Pixel output bus from the tile scheduler to the frame-buffer writer.
// Valid/ready handshake; data is held stable while valid and not ready.
interface ds_tile_scheduler_if;
  import ds_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [CRD_W-1:0] pix_x;
  logic [CRD_W-1:0] pix_y;
  logic [7:0]       pix_z;

  modport master (
    output pix_valid, pix_x, pix_y, pix_z,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_z,
    output pix_ready
  );

endinterface

// File: rtl/ds_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last.
// o_none is set when no request bit is high.
module ds_rr_arbiter #(
  parameter int NUM_TILES = 4,
  parameter int GW = 2
) (
  input  logic [NUM_TILES-1:0] i_req,
  input  logic [GW-1:0]        i_last,
  output logic [GW-1:0]        o_grant,
  output logic                 o_none
);

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin : pick
    int idx;
    idx = 0;
    o_grant = '0;
    o_none = 1'b1;
    for (int k = NUM_TILES; k >= 1; k--) begin
      idx = (int'(i_last) + k) % NUM_TILES;
      if (i_req[idx]) begin
        o_grant = GW'(idx);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ds_tile_scheduler.sv
// Frame controller: seeds tiles, round-robin fetches their pixels.
// Optional DS_SCHED_ORDER_CHECK_EN adds the sticky o_order_err check.
module ds_tile_scheduler
  import ds_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int DIM = 9,
  parameter int ACK_LAT = ACK_LAT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [31:0]             i_seed_base,
  input  logic [31:0]             i_corners,
  output logic [NUM_TILES-1:0]    o_tile_reset,
  output logic [32*NUM_TILES-1:0] o_tile_seed,
  output logic [31:0]             o_tile_corners,
  input  logic [NUM_TILES-1:0]    i_tile_done,
  input  logic [10*NUM_TILES-1:0] i_tile_x,
  input  logic [10*NUM_TILES-1:0] i_tile_y,
  input  logic [8*NUM_TILES-1:0]  i_tile_z,
  output logic [NUM_TILES-1:0]    o_tile_ack,
  ds_tile_scheduler_if.master     pix,
  output logic                    o_busy,
  output logic                    o_frame_done
`ifdef DS_SCHED_ORDER_CHECK_EN
  ,
  output logic                    o_order_err
`endif
);

  localparam int GW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int LW = $clog2(ACK_LAT + 1);

  state_t               r_state;
  logic [31:0]          r_seed;
  logic [GW-1:0]        r_last;
  logic [GW-1:0]        r_g;
  logic [LW-1:0]        r_lat;
  logic [NUM_TILES-1:0] r_fin;
  logic [CW-1:0]        r_row [NUM_TILES];
  logic [CW-1:0]        r_col [NUM_TILES];

  logic [GW-1:0]    w_grant;
  logic             w_none;
  logic [CRD_W-1:0] w_tx;
  logic [CRD_W-1:0] w_ty;
  logic [7:0]       w_tz;

  assign w_tx = i_tile_x[r_g*CRD_W +: CRD_W];
  assign w_ty = i_tile_y[r_g*CRD_W +: CRD_W];
  assign w_tz = i_tile_z[r_g*8 +: 8];

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_seed
    assign o_tile_seed[i*32 +: 32] = tile_seed_of(r_seed, i);
  end

  ds_rr_arbiter #(
    .NUM_TILES(NUM_TILES),
    .GW(GW)
  ) u_arb (
    .i_req  (i_tile_done & ~r_fin),
    .i_last (r_last),
    .o_grant(w_grant),
    .o_none (w_none)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_seed         <= '0;
      r_last         <= GW'(NUM_TILES - 1);
      r_g            <= '0;
      r_lat          <= '0;
      r_fin          <= '0;
      o_tile_corners <= '0;
      o_tile_reset   <= '1;
      o_tile_ack     <= '0;
      o_busy         <= 1'b0;
      o_frame_done   <= 1'b0;
      pix.pix_valid  <= 1'b0;
      pix.pix_x      <= '0;
      pix.pix_y      <= '0;
      pix.pix_z      <= '0;
      for (int i = 0; i < NUM_TILES; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
`ifdef DS_SCHED_ORDER_CHECK_EN
      o_order_err <= 1'b0;
`endif
    end else begin
      o_tile_ack   <= '0;
      o_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_seed         <= i_seed_base;
            o_tile_corners <= i_corners;
            o_tile_reset   <= '1;
            o_busy         <= 1'b1;
            r_state        <= S_RST;
`ifdef DS_SCHED_ORDER_CHECK_EN
            o_order_err    <= 1'b0;
`endif
          end
        end
        S_RST: begin
          o_tile_reset <= '0;
          r_fin        <= '0;
          r_last       <= GW'(NUM_TILES - 1);
          for (int i = 0; i < NUM_TILES; i++) begin
            r_row[i] <= '0;
            r_col[i] <= '0;
          end
          r_state <= S_SEL;
        end
        S_SEL: begin
          if (&r_fin) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            r_state      <= S_FIN;
          end else if (!w_none) begin
            r_g        <= w_grant;
            o_tile_ack <= NUM_TILES'(1) << w_grant;
            r_state    <= S_ACK;
          end
        end
        S_ACK: begin
          r_lat   <= '0;
          r_state <= S_LAT;
        end
        S_LAT: begin
          if (r_lat == LW'(ACK_LAT - 1)) begin
            pix.pix_x     <= CRD_W'(r_g) * CRD_W'(DIM) + w_tx;
            pix.pix_y     <= w_ty;
            pix.pix_z     <= w_tz;
            pix.pix_valid <= 1'b1;
            r_state       <= S_OUT;
`ifdef DS_SCHED_ORDER_CHECK_EN
            if (w_tx != CRD_W'(r_col[r_g]) ||
                w_ty != CRD_W'(r_row[r_g]))
              o_order_err <= 1'b1;
`endif
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_OUT: begin
          if (pix.pix_ready) begin
            pix.pix_valid <= 1'b0;
            r_last        <= r_g;
            r_state       <= S_SEL;
            // Row runs fastest; last row of last col retires the tile.
            if (r_row[r_g] == CW'(DIM - 1)) begin
              r_row[r_g] <= '0;
              r_col[r_g] <= r_col[r_g] + 1'b1;
              if (r_col[r_g] == CW'(DIM - 1))
                r_fin[r_g] <= 1'b1;
            end else begin
              r_row[r_g] <= r_row[r_g] + 1'b1;
            end
          end
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_tile_scheduler.sv
// Randomized bench for ds_tile_scheduler with behavioural tile models.
// Define DS_SCHED_ORDER_CHECK_EN to also exercise o_order_err.
module tb_ds_tile_scheduler;
  import ds_pkg::*;

  localparam int N = 2;
  localparam int DIM = 9;
  localparam int AL = 3;
  localparam int NPIX = N * DIM * DIM;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] seed_base = '0;
  logic [31:0] corners = '0;
  logic [N-1:0] tile_reset, tile_done, tile_ack;
  logic [32*N-1:0] tile_seed;
  logic [31:0] tile_corners;
  logic [10*N-1:0] tile_x, tile_y;
  logic [8*N-1:0] tile_z;
  logic busy, frame_done;
`ifdef DS_SCHED_ORDER_CHECK_EN
  logic order_err;
`endif

  ds_tile_scheduler_if pif();

  ds_tile_scheduler #(
    .NUM_TILES(N),
    .DIM(DIM),
    .ACK_LAT(AL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_start(start),
    .i_seed_base(seed_base),
    .i_corners(corners),
    .o_tile_reset(tile_reset),
    .o_tile_seed(tile_seed),
    .o_tile_corners(tile_corners),
    .i_tile_done(tile_done),
    .i_tile_x(tile_x),
    .i_tile_y(tile_y),
    .i_tile_z(tile_z),
    .o_tile_ack(tile_ack),
    .pix(pif),
    .o_busy(busy),
    .o_frame_done(frame_done)
`ifdef DS_SCHED_ORDER_CHECK_EN
    ,
    .o_order_err(order_err)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tile models: the k-th fetch yields col k/DIM, row k%DIM.
  int fidx[N], kcur[N], pend[N], tcyc[N];
  int done_dly[N];
  bit swap = 1'b0;
  int zsalt = 0;

  function automatic logic [7:0] zf(input int g, input int k);
    return 8'(k * 37 + g * 101 + zsalt);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (tile_reset[i]) begin
        fidx[i] <= 0;
        kcur[i] <= -1;
        pend[i] <= 0;
        tcyc[i] <= 0;
      end else begin
        tcyc[i] <= tcyc[i] + 1;
        if (tile_ack[i]) begin
          kcur[i] <= fidx[i];
          fidx[i] <= fidx[i] + 1;
          pend[i] <= AL - 1;
        end else if (pend[i] > 0) begin
          pend[i] <= pend[i] - 1;
        end
      end
    end
  end

  always_comb begin
    int c, r;
    c = 0;
    r = 0;
    tile_x = '0;
    tile_y = '0;
    tile_z = '0;
    tile_done = '0;
    for (int i = 0; i < N; i++) begin
      tile_done[i] = !tile_reset[i] && (tcyc[i] >= done_dly[i]);
      if (kcur[i] >= 0 && pend[i] == 0) begin
        c = kcur[i] / DIM;
        r = kcur[i] % DIM;
        tile_x[i*10 +: 10] = 10'(swap ? r : c);
        tile_y[i*10 +: 10] = 10'(swap ? c : r);
        tile_z[i*8 +: 8] = zf(i, kcur[i]);
      end else begin
        tile_x[i*10 +: 10] = 10'h155;
        tile_y[i*10 +: 10] = 10'h2AA;
        tile_z[i*8 +: 8] = 8'hA5;
      end
    end
  end

  // Reference model of grants and per-tile pixel order.
  int cyc = 0;
  int m_last, n_pix, n_fd, ack_cyc, last_ack, cur_g;
  int xmin1, xmax1;
  int m_cnt[N];
  bit m_fin[N];
  bit chk_per = 1'b0;
  int grants[$];
  logic [N-1:0] prev_done = '0;
  logic [N-1:0] prev_ack = '0;
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  logic [27:0] prev_pix = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [N-1:0] req);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (req[idx] && !m_fin[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clock) begin : mon
    int g, k, ex, ey;
    logic [27:0] cur_pix;
    g = 0;
    cur_pix = {pif.pix_x, pif.pix_y, pif.pix_z};
    if (!reset) begin
      if (tile_ack != '0) begin
        for (int i = 0; i < N; i++) if (tile_ack[i]) g = i;
        check("ack_onehot", 64'($countones(tile_ack)), 64'd1);
        check("rr_grant", 64'(g), 64'(rr_pick(prev_done)));
        check("ack_gap", 64'(prev_ack), 64'd0);
        check("ack_while_valid", 64'(pif.pix_valid), 64'd0);
        if (chk_per && last_ack >= 0)
          check("ack_period", 64'(cyc - last_ack), 64'(AL + 3));
        last_ack = cyc;
        ack_cyc = cyc;
        cur_g = g;
        grants.push_back(g);
      end
      if (pif.pix_valid && !prev_valid)
        check("fetch_lat", 64'(cyc - ack_cyc), 64'(AL + 1));
      if (pif.pix_valid && prev_valid && !prev_acc)
        check("stall_hold", 64'(cur_pix), 64'(prev_pix));
      if (pif.pix_valid && pif.pix_ready) begin
        k = m_cnt[cur_g];
        ex = cur_g * DIM + (swap ? k % DIM : k / DIM);
        ey = swap ? k / DIM : k % DIM;
        check("pixel", 64'(cur_pix),
              64'({10'(ex), 10'(ey), zf(cur_g, k)}));
        if (cur_g == 1) begin
          if (int'(pif.pix_x) < xmin1) xmin1 = int'(pif.pix_x);
          if (int'(pif.pix_x) > xmax1) xmax1 = int'(pif.pix_x);
        end
        m_cnt[cur_g] = k + 1;
        if (k + 1 == DIM * DIM) m_fin[cur_g] = 1'b1;
        m_last = cur_g;
        n_pix++;
      end
      if (frame_done) begin
        n_fd++;
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    prev_done = tile_done;
    prev_ack = tile_ack;
    prev_valid = pif.pix_valid;
    prev_acc = pif.pix_valid && pif.pix_ready;
    prev_pix = cur_pix;
  end

  logic [31:0] exp_seed, exp_corn;
  bit fd_seen;

  task automatic begin_frame(input logic [31:0] s, input logic [31:0] c);
    m_last = N - 1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    foreach (m_fin[i]) m_fin[i] = 1'b0;
    n_pix = 0;
    n_fd = 0;
    last_ack = -1;
    grants.delete();
    xmin1 = 1023;
    xmax1 = 0;
    zsalt = int'($urandom % 256);
    exp_seed = s;
    exp_corn = c;
    @(posedge clock);
    #1 start = 1'b1;
    seed_base = s;
    corners = c;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("start_busy", 64'(busy), 64'd1);
    check("start_treset", 64'(tile_reset), 64'({N{1'b1}}));
    for (int i = 0; i < N; i++)
      check("seed", 64'(tile_seed[i*32 +: 32]),
            64'(s ^ (32'(i) * 32'h9E3779B9)));
    check("corners", 64'(tile_corners), 64'(c));
`ifdef DS_SCHED_ORDER_CHECK_EN
    check("oerr_clear", 64'(order_err), 64'd0);
`endif
  endtask

  task automatic run_frame(input bit rnd, input int bound);
    fd_seen = 1'b0;
    fork
      begin
        for (int t = 0; t < bound; t++) begin
          @(negedge clock);
          if (frame_done) begin
            fd_seen = 1'b1;
            break;
          end
        end
      end
      begin
        forever begin
          @(posedge clock);
          #1 pif.pix_ready = rnd ? 1'($urandom % 2) : 1'b1;
        end
      end
    join_any
    disable fork;
    pif.pix_ready = 1'b1;
  endtask

  task automatic finish_frame();
    check("frame_done_seen", 64'(fd_seen), 64'd1);
    repeat (5) @(negedge clock);
    check("frame_done_once", 64'(n_fd), 64'd1);
    check("pix_count", 64'(n_pix), 64'(NPIX));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first1;
    logic [27:0] hold;
    int na;
    pif.pix_ready = 1'b1;
    done_dly[0] = 0;
    done_dly[1] = 0;

    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_treset", 64'(tile_reset), 64'({N{1'b1}}));
      check("rst_ctrl", 64'({busy, frame_done, pif.pix_valid, tile_ack}),
            64'd0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_pix", 64'({pif.pix_x, pif.pix_y, pif.pix_z}), 64'd0);
    check("rst_corners", 64'(tile_corners), 64'd0);
    check("rst_seed1", 64'(tile_seed[63:32]), 64'(32'h9E3779B9));
    check("rst_busy", 64'(busy), 64'd0);

    // Frame 1: both tiles ready at once, sink always ready.
    chk_per = 1'b1;
    begin_frame($urandom, $urandom);
    run_frame(1'b0, 5000);
    chk_per = 1'b0;
    finish_frame();
    for (int i = 0; i < 4; i++)
      check("rr_order", 64'(grants[i]), 64'(i % 2));
    check("t1_xmin", 64'(xmin1), 64'd9);
    check("t1_xmax", 64'(xmax1), 64'd17);

    // Frame 2: late tile 1, backpressure, start while busy.
    done_dly[1] = 500;
    pif.pix_ready = 1'b0;
    begin_frame($urandom, $urandom);
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (pif.pix_valid) break;
    end
    check("bp_valid", 64'(pif.pix_valid), 64'd1);
    hold = {pif.pix_x, pif.pix_y, pif.pix_z};
    na = grants.size();
    repeat (20) @(negedge clock);
    check("bp_hold", 64'({pif.pix_x, pif.pix_y, pif.pix_z}), 64'(hold));
    check("bp_no_ack", 64'(grants.size()), 64'(na));
    check("bp_valid_held", 64'(pif.pix_valid), 64'd1);
    @(posedge clock);
    #1 start = 1'b1;
    seed_base = ~exp_seed;
    corners = ~exp_corn;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("busy_start_seed", 64'(tile_seed[31:0]), 64'(exp_seed));
    check("busy_start_corn", 64'(tile_corners), 64'(exp_corn));
    check("busy_start_busy", 64'(busy), 64'd1);
    run_frame(1'b1, 20000);
    finish_frame();
    first1 = -1;
    foreach (grants[i]) if (first1 < 0 && grants[i] == 1) first1 = i;
    check("late_t0_first", 64'(grants[0]), 64'd0);
    check("late_t1_waits", 64'(first1 >= 10), 64'd1);

    // Frame 3: aborted by a mid-frame reset.
    done_dly[0] = int'($urandom_range(0, 200));
    done_dly[1] = int'($urandom_range(0, 200));
    begin_frame($urandom, $urandom);
    run_frame(1'b1, 300);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_valid", 64'(pif.pix_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (30) @(negedge clock);
    check("abort_no_done", 64'(n_fd), 64'd0);

    // Frame 4: full random frame after the abort.
    done_dly[0] = int'($urandom_range(0, 300));
    done_dly[1] = int'($urandom_range(0, 300));
    begin_frame($urandom, $urandom);
    run_frame(1'b1, 20000);
    finish_frame();
`ifdef DS_SCHED_ORDER_CHECK_EN
    check("oerr_clean", 64'(order_err), 64'd0);
    swap = 1'b1;
    begin_frame($urandom, $urandom);
    run_frame(1'b0, 5000);
    finish_frame();
    check("oerr_swapped", 64'(order_err), 64'd1);
    swap = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
